// File: rtl/logic_unit_arbiter.sv
// Round-robin arbiter that time-shares one registered bitwise logic unit among NREQ requesters.
// Each grant runs IDLE -> EXEC -> RESP and returns one tagged result under valid/ready backpressure.
module logic_unit_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [3*NREQ-1:0]     req_op,
  input  logic [WIDTH*NREQ-1:0] req_a,
  input  logic [WIDTH*NREQ-1:0] req_b,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [WIDTH-1:0]      rsp_data,
  output logic [IDW-1:0]        rsp_id,
  output logic                  rsp_err,
  output logic                  busy
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0]   w_q;
  logic [2:0]       op_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic             rsp_valid_q;
  logic [WIDTH-1:0] rsp_data_q;
  logic [IDW-1:0]   rsp_id_q;
  logic             rsp_err_q;
  logic             busy_q;

  logic             any_valid;
  logic [IDW-1:0]   win;
  logic [IDW-1:0]   cand;
  int               idx;
  logic [2:0]       sel_op;
  logic [WIDTH-1:0] sel_a, sel_b;
  logic [WIDTH:0]   result;

  // Returns {err, data}; opcode 7 is the only illegal encoding.
  function automatic logic [WIDTH:0] logic_op(input logic [2:0] op,
                                              input logic [WIDTH-1:0] a,
                                              input logic [WIDTH-1:0] b);
    logic [WIDTH:0] r;
    case (op)
      3'd0:    r = {1'b0, a & b};
      3'd1:    r = {1'b0, a | b};
      3'd2:    r = {1'b0, ~a};
      3'd3:    r = {1'b0, ~(a & b)};
      3'd4:    r = {1'b0, ~(a | b)};
      3'd5:    r = {1'b0, a ^ b};
      3'd6:    r = {1'b0, ~(a ^ b)};
      default: r = {1'b1, {WIDTH{1'b0}}};
    endcase
    return r;
  endfunction

  // Search starts at rr_ptr and wraps explicitly so non-power-of-two NREQ stays in range.
  always_comb begin
    any_valid = 1'b0;
    win       = '0;
    cand      = '0;
    idx       = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(rr_ptr_q) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      cand = IDW'(idx);
      if (!any_valid && req_valid[cand]) begin
        any_valid = 1'b1;
        win       = cand;
      end
    end
  end

  always_comb begin
    sel_op = '0;
    sel_a  = '0;
    sel_b  = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (win == IDW'(k)) begin
        sel_op = req_op[3*k +: 3];
        sel_a  = req_a[WIDTH*k +: WIDTH];
        sel_b  = req_b[WIDTH*k +: WIDTH];
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (!rst && state_q == IDLE && any_valid) req_ready[win] = 1'b1;
  end

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    case (state_q)
      IDLE: if (any_valid) state_d = EXEC;
      EXEC: state_d = RESP;
      RESP: begin
        if (rsp_valid_q && rsp_ready) begin
          state_d  = IDLE;
          rr_ptr_d = (w_q == IDW'(NREQ - 1)) ? '0 : w_q + IDW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign result = logic_op(op_q, a_q, b_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_id_q    <= '0;
      rsp_err_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      busy_q   <= (state_d != IDLE);
      if (state_q == EXEC) begin
        rsp_valid_q <= 1'b1;
        rsp_data_q  <= result[WIDTH-1:0];
        rsp_err_q   <= result[WIDTH];
        rsp_id_q    <= w_q;
      end else if (state_q == RESP && rsp_ready) begin
        rsp_valid_q <= 1'b0;
      end
    end
  end

  // Operand capture needs no reset: it is only consumed after a fresh grant.
  always_ff @(posedge clk) begin
    if (state_q == IDLE && any_valid) begin
      op_q <= sel_op;
      a_q  <= sel_a;
      b_q  <= sel_b;
      w_q  <= win;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_err   = rsp_err_q;
  assign busy      = busy_q;

endmodule

// File: doc/logic_unit_arbiter.md
Name: logic_unit_arbiter

Overview:
- Shares one registered multi-function bitwise logic unit (AND/OR/NOT/NAND/NOR/XOR/XNOR) among NREQ requesters.
- Uses a round-robin arbiter and a 3-state FSM.
- Each requester presents an opcode and two operands with valid/ready; the block returns one tagged result with valid/ready backpressure.
- Sits between requesting engines and the shared gate datapath, so the gate functions are instantiated once rather than per requester.

Parameters:
- NREQ, 4, number of requesters (2..16, need not be a power of two)
- WIDTH, 8, operand/result width in bits
- IDW, $clog2(NREQ), width of rsp_id (derived; not overridden)

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- req_valid  input  NREQ  per-requester request valid
- req_ready  output  NREQ  per-requester accept; one-hot or zero
- req_op  input  3*NREQ  opcode; requester i occupies bits [3i+2:3i]
- req_a  input  WIDTH*NREQ  operand A; requester i occupies bits [WIDTH*i+WIDTH-1:WIDTH*i]
- req_b  input  WIDTH*NREQ  operand B; same packing as req_a
- rsp_valid  output  1  response valid
- rsp_ready  input  1  response consumer ready
- rsp_data  output  WIDTH  result
- rsp_id  output  IDW  index of the requester that issued the request
- rsp_err  output  1  illegal opcode flag
- busy  output  1  high whenever state != IDLE

Behaviour:
- Clocking and reset:
  - One clock, clk. Reset is synchronous and active-high on rst.
  - Reset forces state=IDLE, rr_ptr=0, rsp_valid=0, rsp_data=0, rsp_id=0, rsp_err=0, busy=0, and req_ready=0 during the reset cycle.
- Reset mid-operation: any in-flight transaction is dropped and no response is issued. Requesters see no req_ready until the first cycle after rst deasserts.
- Opcode encoding (bitwise over WIDTH):
  - 0 = a&b
  - 1 = a|b
  - 2 = ~a (b ignored)
  - 3 = ~(a&b)
  - 4 = ~(a|b)
  - 5 = a^b
  - 6 = ~(a^b)
  - 7 = illegal: rsp_data=0, rsp_err=1
  - Legal opcodes give rsp_err=0.
- FSM, three states:
  - IDLE:
    - If any req_valid is set, select winner w by round-robin: search indices rr_ptr, rr_ptr+1, ..., wrapping modulo NREQ.
    - Drive req_ready[w]=1 combinationally in this cycle; all other bits are 0.
    - Latch op, a, b and w into internal registers. Next state is EXEC.
    - If no req_valid is set, req_ready=0 and the FSM stays in IDLE.
  - EXEC: compute the result from the latched operands. At the clock edge, register rsp_data, rsp_err and rsp_id=w, and set rsp_valid=1. Next state is RESP.
  - RESP:
    - Hold rsp_valid, rsp_data, rsp_id and rsp_err stable while rsp_ready=0.
    - On rsp_valid&&rsp_ready: clear rsp_valid, set rr_ptr=(w+1) mod NREQ (explicit wrap, no power-of-two truncation), next state IDLE.
    - rsp_data, rsp_id and rsp_err keep their last values after the handshake.
- Timing:
  - Latency: accept handshake in cycle T; rsp_valid rises in cycle T+2.
  - Minimum issue interval is 3 cycles, because requests are accepted only in IDLE.
- Request handshake rules:
  - req_ready is asserted only in IDLE, and only toward an index whose req_valid is 1.
  - Requesters hold valid, op and operands stable until they see ready.
  - A requester that deasserts valid before it is granted is simply skipped; this is not an error.
  - req_ready may depend combinationally on req_valid. No other input-to-output combinational path exists.
- Simultaneous events: multiple valid requests in the same IDLE cycle resolve strictly by the round-robin order above. No requester waits more than NREQ-1 grants.
- busy = (state != IDLE), registered with the state.

Test Plan:
- Single request: requester 0, op=0, a=8'hF0, b=8'h3C, rsp_ready=1. Required: req_ready[0] in cycle T; at T+2 rsp_valid=1, rsp_data=8'h30, rsp_id=0, rsp_err=0; busy high in T+1 and T+2.
- Fairness: all 4 req_valid held high with op=5, requester i sends a=i, b=8'hFF. Required grant order 0,1,2,3,0. Responses are 8'hFF, 8'hFE, 8'hFD, 8'hFC with rsp_id 0..3 in order; exactly 3 cycles between grants.
- Backpressure: rsp_ready=0 for 5 cycles after rsp_valid rises. Required: rsp_data and rsp_id stable and req_ready all 0 throughout. Raising rsp_ready completes the handshake, and the next grant occurs 1 cycle later.
- Opcodes:
  - op=2, a=8'hA5 gives 8'h5A.
  - op=3, a=b=8'hFF gives 8'h00.
  - op=7 gives rsp_data=0, rsp_err=1.
  - op=6, a=8'h0F, b=8'h0F gives 8'hFF.
- Reset mid-operation: assert rst for 1 cycle while in EXEC. Required next cycle: rsp_valid=0, busy=0, no response for the dropped request. With requesters 0 and 2 valid afterwards, the first grant goes to requester 0 (rr_ptr=0).
- Wrap with NREQ=3: only requesters 0 and 2 valid, first grant is to 2. Required: rr_ptr becomes 0 and the next grant goes to requester 0; rsp_id stays within 0..2.
